// File: rtl/axi_lite_master_bridge.sv
// AXI-lite master bridge: turns a single-outstanding CPU memory request into
// one AXI-lite write (AW/W/B) or read (AR/R) transaction at a time.
module axi_lite_master_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_valid,
    input  logic                    w_ready,
    input  logic [1:0]              b_resp,
    input  logic                    b_valid,
    output logic                    b_ready,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_valid,
    output logic                    r_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wmask_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    aw_complete;
    logic                    w_complete;
    logic                    unused_resp_bits;

    // Only resp[1] distinguishes error from success for the CPU.
    assign unused_resp_bits = ^{b_resp[0], r_resp[0]};

    assign req_ready   = (state == IDLE);
    assign aw_addr     = addr_q;
    assign ar_addr     = addr_q;
    assign w_data      = wdata_q;
    assign w_strb      = wmask_q;
    assign aw_complete = aw_done | (aw_valid & aw_ready);
    assign w_complete  = w_done | (w_valid & w_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (req_wen) begin
                            state    <= WADDR;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                        end else begin
                            state    <= RADDR;
                            ar_valid <= 1'b1;
                        end
                    end
                end
                // AW and W finish independently; the done flags remember whichever came first.
                WADDR: begin
                    if (aw_valid && aw_ready) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_valid && w_ready) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if (aw_complete && w_complete) begin
                        state   <= WRESP;
                        b_ready <= 1'b1;
                    end
                end
                WRESP: begin
                    if (b_valid) begin
                        b_ready    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= b_resp[1];
                        state      <= IDLE;
                    end
                end
                RADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_valid) begin
                        r_ready    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= r_resp[1];
                        resp_rdata <= r_data;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: configurable-latency AXI-lite
// slave model plus a scoreboard of expected completions.
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready = 1'b0;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [1:0]  b_resp = 2'b00;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [63:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00;
    logic        r_valid = 1'b0;
    logic        r_ready;

    axi_lite_master_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   resp_cnt = 0;
    int   last_accept = 0;
    logic prev_resp = 1'b0;

    // Slave configuration and observations
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [63:0] cfg_rdata = '0;
    logic        stray_b = 1'b0, stray_r = 1'b0;
    logic        aw_in = 1'b0, w_in = 1'b0, ar_in = 1'b0;
    logic [63:0] aw_first = '0, w_first = '0, ar_first = '0;
    logic [63:0] seen_aw_addr = '0, seen_w_data = '0, seen_ar_addr = '0;
    logic [7:0]  seen_w_strb = '0;
    int          aw_hi_cnt = 0, w_hi_cnt = 0;
    int          unstable = 0, viol = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Slave model: decides ready/valid for the next rising edge from what it sees now.
    always @(negedge clk) begin
        if (aw_valid) begin
            aw_hi_cnt++;
            if (!aw_in) begin aw_first = aw_addr; aw_in = 1'b1; end
            else if (aw_addr !== aw_first) unstable++;
            if (aw_wait >= aw_delay) begin aw_ready = 1'b1; seen_aw_addr = aw_addr; end
            else begin aw_ready = 1'b0; aw_wait++; end
        end else begin aw_ready = 1'b0; aw_wait = 0; aw_in = 1'b0; end

        if (w_valid) begin
            w_hi_cnt++;
            if (!w_in) begin w_first = w_data; w_in = 1'b1; end
            else if (w_data !== w_first) unstable++;
            if (w_wait >= w_delay) begin w_ready = 1'b1; seen_w_data = w_data; seen_w_strb = w_strb; end
            else begin w_ready = 1'b0; w_wait++; end
        end else begin w_ready = 1'b0; w_wait = 0; w_in = 1'b0; end

        if (b_ready) begin
            if (b_wait >= b_delay) begin b_valid = 1'b1; b_resp = cfg_bresp; end
            else begin b_valid = 1'b0; b_wait++; end
        end else begin b_valid = stray_b; b_resp = 2'b10; b_wait = 0; end

        if (ar_valid) begin
            if (!ar_in) begin ar_first = ar_addr; ar_in = 1'b1; end
            else if (ar_addr !== ar_first) unstable++;
            if (ar_wait >= ar_delay) begin ar_ready = 1'b1; seen_ar_addr = ar_addr; end
            else begin ar_ready = 1'b0; ar_wait++; end
        end else begin ar_ready = 1'b0; ar_wait = 0; ar_in = 1'b0; end

        if (r_ready) begin
            if (r_wait >= r_delay) begin r_valid = 1'b1; r_data = cfg_rdata; r_resp = cfg_rresp; end
            else begin r_valid = 1'b0; r_wait++; end
        end else begin r_valid = stray_r; r_data = 64'hBAD0BAD0BAD0BAD0; r_resp = 2'b10; r_wait = 0; end

        if (b_ready && (aw_valid || w_valid)) viol++;
        if ((aw_valid || w_valid || b_ready) && (ar_valid || r_ready)) viol++;
    end

    // Response monitor: every resp_valid pulse retires the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
                if (mon_e.is_read) checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
                if (mon_e.lat >= 0) checkOutput("resp_latency", 64'(cycle - mon_e.acc_cycle), 64'(mon_e.lat));
                checkOutput("req_ready_at_resp", {63'd0, req_ready}, 64'd1);
            end
            if (prev_resp) checkOutput("resp_pulse_width", 64'd2, 64'd1);
        end
        prev_resp = resp_valid;
    end

    task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wmask, input logic [63:0] exp_rdata,
                                 input logic exp_err, input int exp_lat);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.is_read   = !wen;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.lat       = exp_lat;
        e.acc_cycle = cycle;
        last_accept = cycle;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("resp_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    initial begin
        int a1, a2, base;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("rst_valids", {58'd0, aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid}, 64'd0);
        checkOutput("rst_resp", {resp_rdata[62:0], resp_err}, 64'd0);
        rst = 1'b0;

        // Minimum-latency write
        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00;
        base = resp_cnt;
        applyStimulus(1'b1, 64'h100, 64'h1122334455667788, 8'hFF, '0, 1'b0, 3);
        wait_done();
        checkOutput("w1_aw_addr", seen_aw_addr, 64'h100);
        checkOutput("w1_w_strb", {56'd0, seen_w_strb}, 64'hFF);
        checkOutput("w1_w_data", seen_w_data, 64'h1122334455667788);
        checkOutput("w1_resp_count", 64'(resp_cnt - base), 64'd1);

        // Write with AW delayed by three cycles
        set_delays(3, 0, 0, 0, 0);
        aw_hi_cnt = 0; w_hi_cnt = 0;
        base = resp_cnt;
        applyStimulus(1'b1, 64'h1A0, 64'h0F0E0D0C0B0A0908, 8'h3C, '0, 1'b0, -1);
        wait_done();
        checkOutput("w2_aw_valid_cycles", 64'(aw_hi_cnt), 64'd4);
        checkOutput("w2_w_valid_cycles", 64'(w_hi_cnt), 64'd1);
        checkOutput("w2_aw_addr", seen_aw_addr, 64'h1A0);
        checkOutput("w2_resp_count", 64'(resp_cnt - base), 64'd1);

        // Delayed read
        set_delays(0, 0, 0, 2, 2);
        cfg_rdata = 64'hDEADBEEFCAFEF00D; cfg_rresp = 2'b00;
        base = resp_cnt;
        applyStimulus(1'b0, 64'h108, '0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0, -1);
        wait_done();
        checkOutput("r1_ar_addr", seen_ar_addr, 64'h108);
        checkOutput("r1_resp_count", 64'(resp_cnt - base), 64'd1);
        checkOutput("r1_rdata_hold", resp_rdata, 64'hDEADBEEFCAFEF00D);

        // Error read, then OKAY write, then DECERR write
        set_delays(0, 0, 1, 0, 0);
        cfg_rdata = 64'h0123456789ABCDEF; cfg_rresp = 2'b10;
        applyStimulus(1'b0, 64'h2000, '0, 8'h00, 64'h0123456789ABCDEF, 1'b1, 3);
        wait_done();
        cfg_bresp = 2'b00;
        applyStimulus(1'b1, 64'h2008, 64'h55, 8'h01, '0, 1'b0, 4);
        wait_done();
        checkOutput("rdata_held_after_write", resp_rdata, 64'h0123456789ABCDEF);
        cfg_bresp = 2'b11;
        applyStimulus(1'b1, 64'h2010, 64'h66, 8'h80, '0, 1'b1, 4);
        wait_done();

        // Back-to-back write then read with req_valid held
        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 64'hA5A5A5A55A5A5A5A;
        applyStimulus(1'b1, 64'h300, 64'hFFFF0000FFFF0000, 8'hF0, '0, 1'b0, 3);
        a1 = last_accept;
        applyStimulus(1'b0, 64'h308, '0, 8'h00, 64'hA5A5A5A55A5A5A5A, 1'b0, 3);
        a2 = last_accept;
        wait_done();
        checkOutput("b2b_accept_gap", 64'(a2 - a1), 64'd3);

        // Stray B/R valids while idle must be ignored
        base = resp_cnt;
        stray_b = 1'b1; stray_r = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stray_ready", {62'd0, b_ready, r_ready}, 64'd0);
        end
        stray_b = 1'b0; stray_r = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_no_resp", 64'(resp_cnt - base), 64'd0);

        // Reset in the middle of a stalled write
        set_delays(20, 20, 0, 0, 0);
        base = resp_cnt;
        applyStimulus(1'b1, 64'h400, 64'h77, 8'hFF, '0, 1'b0, -1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("mid_aw_valid", {63'd0, aw_valid}, 64'd1);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_valids", {62'd0, aw_valid, w_valid}, 64'd0);
        checkOutput("mid_rst_idle", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_no_resp", 64'(resp_cnt - base), 64'd0);
        set_delays(0, 0, 0, 0, 0);
        applyStimulus(1'b1, 64'h500, 64'h8899AABBCCDDEEFF, 8'h0F, '0, 1'b0, 3);
        wait_done();
        checkOutput("post_rst_aw_addr", seen_aw_addr, 64'h500);
        checkOutput("post_rst_resp_count", 64'(resp_cnt - base), 64'd1);

        checkOutput("protocol_violations", 64'(viol), 64'd0);
        checkOutput("addr_data_unstable", 64'(unstable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- Converts the pipeline's single-outstanding memory request port into AXI-lite master transactions: one write (AW/W/B) or one read (AR/R) at a time.
- Sits between the CPU memory stage and any AXI-lite slave, e.g. the RAM slave wrapper.
- It is the initiator end of the same AXI-lite channel set the slave wrapper responds on.

Parameters:
DATA_WIDTH, 64, width of the data bus; the strobe width is DATA_WIDTH/8.
ADDR_WIDTH, 64, width of the address bus.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  CPU request present.
req_ready  output  1  bridge can accept a request (state IDLE).
req_wen  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  byte address, forwarded unchanged.
req_wdata  input  DATA_WIDTH  write data.
req_wmask  input  DATA_WIDTH/8  byte write strobes.
resp_valid  output  1  one-cycle pulse: transaction complete.
resp_rdata  output  DATA_WIDTH  read data, valid with resp_valid on reads.
resp_err  output  1  resp[1] of the BRESP or RRESP, valid with resp_valid.
aw_addr, aw_valid  output  ADDR_WIDTH, 1  write address channel.
aw_ready  input  1  write address channel ready.
w_data, w_strb, w_valid  output  DATA_WIDTH, DATA_WIDTH/8, 1  write data channel.
w_ready  input  1  write data channel ready.
b_resp  input  2  write response code.
b_valid  input  1  write response valid.
b_ready  output  1  write response ready.
ar_addr, ar_valid  output  ADDR_WIDTH, 1  read address channel.
ar_ready  input  1  read address channel ready.
r_data, r_resp  input  DATA_WIDTH, 2  read data and read response.
r_valid  input  1  read data valid.
r_ready  output  1  read data ready.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE. All *_valid, b_ready, r_ready, resp_valid and resp_err are 0. All address/data registers and resp_rdata are 0.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA. req_ready = (state==IDLE), combinational.
- Request capture: in IDLE, req_valid=1 latches addr, wdata, wmask and wen into registers.
  - wen=1: next state WADDR; aw_valid and w_valid rise together on the next cycle.
  - wen=0: next state RADDR; ar_valid rises on the next cycle.
  - Requests are ignored outside IDLE.
- WADDR:
  - aw_valid is held until aw_ready is seen (sampled at the clock edge), then drops the next cycle. w_valid behaves the same with w_ready.
  - The two channels complete independently, in either order or the same cycle; per-channel done flags track this.
  - Valid never drops before its ready and address/data never change while valid is high (AXI stability).
  - When both are done: next state WRESP, with b_ready=1 in WRESP.
- WRESP: on b_valid (handshake with b_ready=1):
  - resp_valid=1 for exactly the next cycle; resp_err=b_resp[1].
  - b_ready drops; state returns to IDLE in that same cycle.
- RADDR: ar_valid is held until ar_ready, then state RDATA with r_ready=1.
- RDATA: on r_valid:
  - resp_rdata<=r_data, resp_err<=r_resp[1], resp_valid pulses for one cycle.
  - state returns to IDLE.
  - resp_rdata holds its value until the next read completes.
- Minimum latency (all readies and valids immediate):
  - write: req accepted at cycle 0, AW/W handshake at cycle 1, B at cycle 2, resp_valid at cycle 3.
  - read: same profile with AR and R.
- req_ready is high in the cycle resp_valid is asserted, so back-to-back requests are accepted with no bubble beyond the FSM.
- Boundaries:
  - b_valid or r_valid arriving outside WRESP/RDATA is ignored; ready stays 0.
  - A slave holding ready low stalls indefinitely; there is no timeout.
  - rst asserted mid-transaction drops every valid and ready immediately (asynchronous). The transaction is abandoned with no resp_valid.
  - SLVERR or DECERR is still a completion: resp_valid=1, resp_err=1.

Test Plan:
- Write addr=0x100, wdata=0x1122334455667788, wmask=0xFF; slave with constant readies and OKAY -> aw_addr=0x100, w_strb=0xFF; resp_valid at cycle 3; resp_err=0; req_ready=1 in that cycle.
- Write with aw_ready delayed 3 cycles and w_ready immediate -> w_valid drops after 1 cycle; aw_valid held 4 cycles with stable addr; b_ready rises only after AW completes; exactly one resp_valid.
- Read addr=0x108 with ar_ready delayed 2 cycles and r_valid delayed 2 cycles, r_data=0xDEADBEEFCAFEF00D -> resp_rdata equals that value with a single resp_valid pulse.
- Read returning r_resp=2'b10 -> resp_valid=1, resp_err=1; the next write returning OKAY -> resp_err=0.
- Back-to-back write then read with req_valid held -> second request accepted in the resp_valid cycle of the first; no overlap of AW/W and AR activity.
- rst pulsed while aw_valid=1 -> aw_valid and w_valid are 0 before the next edge; state IDLE; no resp_valid; a subsequent write completes normally.
